// File: rtl/lc3_ctrl.sv
// =============================================================================
// Module      : lc3_ctrl
// Description : Multicycle LC-3 control FSM driving the shared-bus datapath.
// Revision    : 1.0 - initial release
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

module lc3_ctrl #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ir,
    input  logic        n,
    input  logic        z,
    input  logic        p,
    input  logic        mem_ready,
    output logic        ld_mar,
    output logic        ld_mdr,
    output logic        ld_ir,
    output logic        ld_pc,
    output logic        ld_reg,
    output logic        load_nzp,
    output logic [2:0]  gate_sel,
    output logic [1:0]  pc_sel,
    output logic        addr1_sel,
    output logic [1:0]  addr2_sel,
    output logic        marmux_sel,
    output logic        dr_sel,
    output logic        sr1_sel,
    output logic        mdr_sel,
    output logic [1:0]  alu_op,
    output logic        mem_en,
    output logic        mem_we,
    output logic        halted
);

    localparam logic [3:0] c_OP_BR   = 4'h0;
    localparam logic [3:0] c_OP_ADD  = 4'h1;
    localparam logic [3:0] c_OP_LD   = 4'h2;
    localparam logic [3:0] c_OP_ST   = 4'h3;
    localparam logic [3:0] c_OP_JSR  = 4'h4;
    localparam logic [3:0] c_OP_AND  = 4'h5;
    localparam logic [3:0] c_OP_LDR  = 4'h6;
    localparam logic [3:0] c_OP_STR  = 4'h7;
    localparam logic [3:0] c_OP_NOT  = 4'h9;
    localparam logic [3:0] c_OP_LDI  = 4'hA;
    localparam logic [3:0] c_OP_STI  = 4'hB;
    localparam logic [3:0] c_OP_JMP  = 4'hC;
    localparam logic [3:0] c_OP_LEA  = 4'hE;
    localparam logic [3:0] c_OP_TRAP = 4'hF;

    typedef enum logic [4:0] {
        S_RST, S_F1, S_F2, S_F3, S_DEC, S_ALU, S_LEA, S_BR, S_JMP, S_JS1, S_JS2,
        S_ADR, S_RD, S_IND, S_RD2, S_WB, S_SD, S_WR, S_TR1, S_TR2, S_TR3, S_HALT
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       r_ben;
    logic [3:0] w_op;
    logic       w_unused;

    assign w_op     = ir[15:12];
    assign w_unused = ^ir[8:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_RST;
            r_ben   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DEC)
                r_ben <= (ir[11] & n) | (ir[10] & z) | (ir[9] & p);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RST:  w_next = S_F1;
            S_F1:   w_next = S_F2;
            S_F2:   if (mem_ready) w_next = S_F3;
            S_F3:   w_next = S_DEC;
            S_DEC: begin
                case (w_op)
                    c_OP_BR:                     w_next = S_BR;
                    c_OP_ADD, c_OP_AND, c_OP_NOT: w_next = S_ALU;
                    c_OP_LD, c_OP_LDR, c_OP_LDI,
                    c_OP_ST, c_OP_STR, c_OP_STI:  w_next = S_ADR;
                    c_OP_JSR:                    w_next = S_JS1;
                    c_OP_JMP:                    w_next = S_JMP;
                    c_OP_LEA:                    w_next = S_LEA;
                    c_OP_TRAP:                   w_next = S_TR1;
                    default:                     w_next = HALT_ON_ILLEGAL ? S_HALT : S_F1;
                endcase
            end
            S_ALU, S_LEA, S_BR, S_JMP, S_JS2, S_WB, S_TR3: w_next = S_F1;
            S_JS1:  w_next = S_JS2;
            S_ADR:  w_next = (w_op == c_OP_ST || w_op == c_OP_STR) ? S_SD : S_RD;
            // RD is shared by loads, both indirect first reads and the TRAP vector read
            S_RD: begin
                if (mem_ready) begin
                    if (w_op == c_OP_LDI || w_op == c_OP_STI) w_next = S_IND;
                    else if (w_op == c_OP_TRAP)              w_next = S_TR3;
                    else                                     w_next = S_WB;
                end
            end
            S_IND:  w_next = (w_op == c_OP_STI) ? S_SD : S_RD2;
            S_RD2:  if (mem_ready) w_next = S_WB;
            S_SD:   w_next = S_WR;
            S_WR:   if (mem_ready) w_next = S_F1;
            S_TR1:  w_next = S_TR2;
            S_TR2:  w_next = S_RD;
            S_HALT: w_next = S_HALT;
            default: w_next = S_RST;
        endcase
    end

    always_comb begin
        ld_mar     = 1'b0;
        ld_mdr     = 1'b0;
        ld_ir      = 1'b0;
        ld_pc      = 1'b0;
        ld_reg     = 1'b0;
        load_nzp   = 1'b0;
        gate_sel   = 3'd0;
        pc_sel     = 2'd0;
        addr1_sel  = 1'b0;
        addr2_sel  = 2'd0;
        marmux_sel = 1'b0;
        dr_sel     = 1'b0;
        sr1_sel    = 1'b0;
        mdr_sel    = 1'b0;
        alu_op     = 2'd0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        halted     = 1'b0;
        case (r_state)
            S_F1: begin
                gate_sel = 3'd1;
                ld_mar   = 1'b1;
                ld_pc    = 1'b1;
            end
            S_F2, S_RD, S_RD2: begin
                mem_en = 1'b1;
                ld_mdr = mem_ready;
            end
            S_F3: begin
                gate_sel = 3'd4;
                ld_ir    = 1'b1;
            end
            S_ALU: begin
                alu_op   = (w_op == c_OP_AND) ? 2'd1 : (w_op == c_OP_NOT) ? 2'd2 : 2'd0;
                gate_sel = 3'd3;
                ld_reg   = 1'b1;
                load_nzp = 1'b1;
            end
            S_LEA: begin
                addr2_sel  = 2'd2;
                marmux_sel = 1'b1;
                gate_sel   = 3'd2;
                ld_reg     = 1'b1;
                load_nzp   = 1'b1;
            end
            S_BR: begin
                addr2_sel = 2'd2;
                pc_sel    = 2'd1;
                ld_pc     = r_ben;
            end
            S_JMP: begin
                addr1_sel = 1'b1;
                pc_sel    = 2'd1;
                ld_pc     = 1'b1;
            end
            S_JS1, S_TR1: begin
                gate_sel = 3'd1;
                dr_sel   = 1'b1;
                ld_reg   = 1'b1;
            end
            S_JS2: begin
                addr1_sel = ~ir[11];
                addr2_sel = ir[11] ? 2'd3 : 2'd0;
                pc_sel    = 2'd1;
                ld_pc     = 1'b1;
            end
            S_ADR: begin
                if (w_op == c_OP_LDR || w_op == c_OP_STR) begin
                    addr1_sel = 1'b1;
                    addr2_sel = 2'd1;
                end else begin
                    addr2_sel = 2'd2;
                end
                marmux_sel = 1'b1;
                gate_sel   = 3'd2;
                ld_mar     = 1'b1;
            end
            S_IND: begin
                gate_sel = 3'd4;
                ld_mar   = 1'b1;
            end
            S_WB: begin
                gate_sel = 3'd4;
                ld_reg   = 1'b1;
                load_nzp = 1'b1;
            end
            S_SD: begin
                sr1_sel  = 1'b1;
                alu_op   = 2'd3;
                gate_sel = 3'd3;
                mdr_sel  = 1'b1;
                ld_mdr   = 1'b1;
            end
            S_WR: begin
                mem_en = 1'b1;
                mem_we = 1'b1;
            end
            S_TR2: begin
                gate_sel = 3'd2;
                ld_mar   = 1'b1;
            end
            S_TR3: begin
                gate_sel = 3'd4;
                pc_sel   = 2'd2;
                ld_pc    = 1'b1;
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

`default_nettype wire
